// File: rtl/spi_pkg.sv
// spi_pkg: shared types and defaults for the SPI master/slave pair.
//   state_t    FSM states of the receiver (IDLE, SHIFT)
//   WIDTH_DEF  default bits per SPI word
//   SYNC_DEF   default synchronizer depth, shared with spi_master
//   cnt_width  bit counter width able to hold 0..w
//   CNT_W      counter width for the default word size
package spi_pkg;

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam int WIDTH_DEF = 8;
   localparam int SYNC_DEF  = 2;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-stage synchronizer for an asynchronous pin with edge detect.
//   clk    system clock
//   reset  asynchronous active-low reset
//   d      asynchronous input pin
//   rise   one-clk pulse on a synchronized 0->1 transition
//   fall   one-clk pulse on a synchronized 1->0 transition
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter int N = SYNC_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [N-1:0] sync;
   logic         prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[N-2:0], d};
         prev <= sync[N-1];
      end
   end

   assign rise = sync[N-1] & ~prev;
   assign fall = ~sync[N-1] & prev;

endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampling mode-0 SPI responder; deserializes MSB-first words
// tagged with dc and shifts a buffered word back out on miso.
//   clk, reset          system clock, asynchronous active-low reset
//   sce, sclk, mosi, dc asynchronous SPI pins (sce active-low)
//   miso                serial data out, MSB first
//   rx_data, rx_dc      last received word and its dc level
//   rx_valid            one-clk strobe for a new rx_data/rx_dc
//   tx_data, tx_load    word (and its load strobe) returned on the next word
//   busy                high while a frame is open
//   overrun, frame_err  sticky flags, cleared by clr_flags
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int SYNC_STAGES = SYNC_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sce,
   input  logic             sclk,
   input  logic             mosi,
   input  logic             dc,
   output logic             miso,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_dc,
   output logic             rx_valid,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_load,
   output logic             busy,
   output logic             overrun,
   output logic             frame_err,
   input  logic             clr_flags
);

   localparam int CW = cnt_width(WIDTH);
   localparam int GW = $clog2(2 * WIDTH + 1);
   localparam logic [GW-1:0] GAP_MAX = GW'(2 * WIDTH);

   logic                   sce_rise, sce_fall, sclk_rise, sclk_fall;
   logic [SYNC_STAGES-1:0] mosi_q, dc_q;
   logic                   mosi_s, dc_s;
   state_t                 state, state_nxt;
   logic [CW-1:0]          cnt, cnt_adv, cnt_nxt;
   logic [WIDTH-2:0]       shift_rx;
   logic [WIDTH-1:0]       shift_tx, tx_buf;
   logic [GW-1:0]          gap;
   logic                   start, done, err, reload;

   spi_sync_edge #(.N(SYNC_STAGES)) u_sce (
      .clk(clk), .reset(reset), .d(sce), .rise(sce_rise), .fall(sce_fall)
   );

   spi_sync_edge #(.N(SYNC_STAGES)) u_sclk (
      .clk(clk), .reset(reset), .d(sclk), .rise(sclk_rise), .fall(sclk_fall)
   );

   // Data pins share the sclk pipeline depth so they line up with sclk_rise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mosi_q <= '0;
         dc_q   <= '0;
      end else begin
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
         dc_q   <= {dc_q[SYNC_STAGES-2:0], dc};
      end
   end

   assign mosi_s = mosi_q[SYNC_STAGES-1];
   assign dc_s   = dc_q[SYNC_STAGES-1];

   // The sclk sample is applied before the sce check, so a word completing
   // on the closing edge still counts as a clean frame end.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      cnt_adv   = '0;
      cnt_nxt   = '0;
      if (state == IDLE) begin
         start     = sce_fall;
         state_nxt = sce_fall ? SHIFT : IDLE;
      end else begin
         done      = sclk_rise && cnt == CW'(WIDTH - 1);
         cnt_adv   = done ? '0 : cnt + CW'(sclk_rise);
         err       = sce_rise && cnt_adv != '0;
         cnt_nxt   = sce_rise ? '0 : cnt_adv;
         state_nxt = sce_rise ? IDLE : SHIFT;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // A falling edge at a word boundary starts the next word from the buffer.
   assign reload = start || (state == SHIFT && sclk_fall && cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         shift_rx  <= '0;
         shift_tx  <= '0;
         tx_buf    <= '0;
         rx_data   <= '0;
         rx_dc     <= 1'b0;
         rx_valid  <= 1'b0;
         gap       <= GAP_MAX;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         rx_valid <= done;
         if (done) begin
            rx_data <= {shift_rx, mosi_s};
            rx_dc   <= dc_s;
         end
         if (state == SHIFT && sclk_rise) shift_rx <= {shift_rx[WIDTH-3:0], mosi_s};
         if (reload) shift_tx <= tx_buf;
         else if (state == SHIFT && sclk_fall) shift_tx <= shift_tx << 1;
         if (tx_load) tx_buf <= tx_data;
         // Clocks since the last completed word, saturating at 2*WIDTH.
         gap       <= done ? '0 : (gap == GAP_MAX ? gap : gap + 1'b1);
         overrun   <= clr_flags ? 1'b0 : overrun | (done && gap != GAP_MAX);
         frame_err <= clr_flags ? 1'b0 : frame_err | err;
      end
   end

   assign busy = state == SHIFT;
   assign miso = busy & shift_tx[WIDTH-1];

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: scoreboard bench driving a mode-0 SPI master model into spi_slave_rx.
module tb_spi_slave_rx;

   logic       clk = 1'b0, reset = 1'b0;
   logic       sce = 1'b1, sclk = 1'b0, mosi = 1'b0, dc = 1'b0;
   logic       tx_load = 1'b0, clr_flags = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       miso, rx_dc, rx_valid, busy, overrun, frame_err;
   logic [7:0] rx_data;

   int         n_cmp = 0, n_bad = 0, n_valid = 0;
   logic [8:0] sb[$];
   logic [8:0] sb_exp;
   logic [7:0] got;

   always #5 clk = ~clk;

   spi_slave_rx dut (
      .clk(clk), .reset(reset), .sce(sce), .sclk(sclk), .mosi(mosi), .dc(dc),
      .miso(miso), .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_load(tx_load), .busy(busy), .overrun(overrun),
      .frame_err(frame_err), .clr_flags(clr_flags)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rx_valid) begin
         n_valid++;
         if (sb.size() == 0) check("rx_unexpected", 32'(sb.size()), 32'd1);
         else begin
            sb_exp = sb.pop_front();
            check("rx_word", 32'({rx_dc, rx_data}), 32'(sb_exp));
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bits(input logic [7:0] d, input int n, input logic dcv, input int half,
                       input logic chk_busy, output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i > 7 - n; i--) begin
         mosi = d[i];
         dc   = (i == 0) ? dcv : 1'($urandom);
         wait_clk(half);
         sclk = 1'b1;
         r[i] = miso;
         if (chk_busy) check("busy_in_frame", 32'(busy), 32'd1);
         wait_clk(half);
         sclk = 1'b0;
      end
   endtask

   task automatic word(input logic [7:0] d, input logic dcv, input int half,
                       input logic chk_busy, input logic chk_miso, input logic [7:0] exp_miso);
      logic [7:0] r;
      sb.push_back({dcv, d});
      bits(d, 8, dcv, half, chk_busy, r);
      if (chk_miso) check("miso_word", 32'(r), 32'(exp_miso));
   endtask

   task automatic frame_open();
      sce = 1'b0;
      wait_clk(6);
   endtask

   task automatic frame_close();
      wait_clk(4);
      sce = 1'b1;
      wait_clk(10);
   endtask

   task automatic load_tx(input logic [7:0] v);
      tx_data = v;
      tx_load = 1'b1;
      wait_clk(1);
      tx_load = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      wait_clk(1);
      clr_flags = 1'b0;
      wait_clk(1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"}, 32'(miso), 32'd0);
      check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
      check({tag, "_rx_dc"}, 32'(rx_dc), 32'd0);
      check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_overrun"}, 32'(overrun), 32'd0);
      check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      wait_clk(3);
      check_reset_outputs("reset");
      reset = 1'b1;
      wait_clk(5);

      // single word, tx buffer still at its reset value
      frame_open();
      word(8'hA3, 1'b0, 4, 1'b0, 1'b1, 8'h00);
      frame_close();
      check("t1_valid_count", 32'(n_valid), 32'd1);
      check("t1_frame_err", 32'(frame_err), 32'd0);
      check("t1_busy_idle", 32'(busy), 32'd0);

      // loaded tx word returned while receiving
      load_tx(8'h5C);
      frame_open();
      word(8'h3A, 1'b0, 4, 1'b0, 1'b1, 8'h5C);
      frame_close();
      check("t2_valid_count", 32'(n_valid), 32'd2);

      // back-to-back words in one frame, same tx word resent
      load_tx(8'h96);
      frame_open();
      word(8'h12, 1'b0, 4, 1'b1, 1'b1, 8'h96);
      word(8'h34, 1'b1, 4, 1'b1, 1'b1, 8'h96);
      frame_close();
      check("t3_valid_count", 32'(n_valid), 32'd4);
      check("t3_busy_idle", 32'(busy), 32'd0);
      check("t3_frame_err", 32'(frame_err), 32'd0);
      check("t3_overrun", 32'(overrun), 32'd0);

      // truncated frame
      frame_open();
      bits(8'hC5, 5, 1'b0, 4, 1'b0, got);
      frame_close();
      check("t4_valid_count", 32'(n_valid), 32'd4);
      check("t4_frame_err_set", 32'(frame_err), 32'd1);
      wait_clk(20);
      check("t4_frame_err_sticky", 32'(frame_err), 32'd1);
      pulse_clr();
      check("t4_frame_err_clr", 32'(frame_err), 32'd0);
      frame_open();
      word(8'hFF, 1'b1, 4, 1'b0, 1'b1, 8'h96);
      frame_close();
      check("t4_valid_count2", 32'(n_valid), 32'd5);
      check("t4_frame_err_after", 32'(frame_err), 32'd0);

      // reset in the middle of a word
      frame_open();
      bits(8'h81, 3, 1'b0, 4, 1'b0, got);
      reset = 1'b0;
      #1;
      check_reset_outputs("midreset");
      wait_clk(2);
      sce = 1'b1;
      wait_clk(2);
      reset = 1'b1;
      wait_clk(5);
      frame_open();
      word(8'h81, 1'b1, 4, 1'b0, 1'b1, 8'h00);
      frame_close();
      check("t5_valid_count", 32'(n_valid), 32'd6);
      check("t5_frame_err", 32'(frame_err), 32'd0);

      // sclk activity with the chip deselected
      for (int i = 0; i < 16; i++) begin
         mosi = 1'($urandom);
         sclk = ~sclk;
         wait_clk(3);
         check("t6_miso", 32'(miso), 32'd0);
         check("t6_busy", 32'(busy), 32'd0);
      end
      wait_clk(10);
      check("t6_valid_count", 32'(n_valid), 32'd6);

      // sclk far above the allowed ratio: two words within 2*WIDTH clk
      check("t7_overrun_before", 32'(overrun), 32'd0);
      frame_open();
      word(8'hC3, 1'b0, 1, 1'b0, 1'b0, 8'h00);
      word(8'h5A, 1'b1, 1, 1'b0, 1'b0, 8'h00);
      frame_close();
      check("t7_valid_count", 32'(n_valid), 32'd8);
      check("t7_overrun_set", 32'(overrun), 32'd1);
      pulse_clr();
      check("t7_overrun_clr", 32'(overrun), 32'd0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
Display-side SPI responder that receives the command/data byte stream produced by the team's SPI master (sce, sclk, mosi, dc) and returns a byte on miso.
- It oversamples all SPI pins with the system clock, deserializes MSB-first bytes, and tags each byte with the dc level.
- It presents each byte to the core on a single-cycle strobe.
- It serves as the bench model of the LCD controller and as the receive front-end of an on-chip display emulator.

Parameters:
- WIDTH, 8, bits per SPI word.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous SPI input (legal values 2 or 3).

Ports:
- clk  input  1  system clock; must run at least 8x sclk.
- reset  input  1  asynchronous, active-low reset; resets all state immediately when low.
- sce  input  1  chip enable, active-low, asynchronous to clk.
- sclk  input  1  SPI clock, mode 0 (idle low, sample on rising edge), asynchronous to clk.
- mosi  input  1  serial data in, MSB first.
- dc  input  1  data/command select, sampled with the LSB.
- miso  output  1  serial data out, MSB first.
- rx_data  output  WIDTH  last received word.
- rx_dc  output  1  dc level captured with the last word.
- rx_valid  output  1  one-clk strobe marking a new rx_data/rx_dc.
- tx_data  input  WIDTH  word returned on the next transfer.
- tx_load  input  1  one-clk strobe that latches tx_data into the transmit buffer.
- busy  output  1  high while a word is being shifted.
- overrun  output  1  sticky flag.
- frame_err  output  1  sticky flag.
- clr_flags  input  1  clears overrun and frame_err.

Behaviour:
- Reset values (reset low): miso=0, rx_data=0, rx_dc=0, rx_valid=0, busy=0, overrun=0, frame_err=0, tx buffer=0, bit counter=0, state=IDLE.
- Synchronizers: sce, sclk, mosi and dc each pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk and sce by comparing with one extra registered copy.
- Latency: a pin transition becomes visible to the FSM SYNC_STAGES+1 clk after it occurs.
- FSM state IDLE:
  - miso=0, busy=0.
  - On a synchronized sce falling edge: load shift_tx from the tx buffer, drive miso=shift_tx[WIDTH-1], clear the bit counter, go to SHIFT.
- FSM state SHIFT, busy=1:
  - Synchronized sclk rising edge: shift_rx <= {shift_rx[WIDTH-2:0], mosi_s} and increment the bit counter.
  - When the counter reaches WIDTH on that edge: in the next clk, rx_data <= the completed word, rx_dc <= dc_s at that edge, rx_valid=1 for exactly one clk, counter <= 0.
  - Synchronized sclk falling edge: shift_tx shifts left and miso = the new MSB.
  - After a completed word, the next falling edge presents the MSB of a freshly reloaded tx buffer. Back-to-back words need no sce toggle.
  - Synchronized sce rising edge with counter==0: go to IDLE; no error.
  - Synchronized sce rising edge with counter!=0: discard the partial word, set frame_err, go to IDLE; no rx_valid.
- Simultaneous events:
  - sce rising and sclk rising in the same clk: the sclk sample is applied first, then the sce check.
  - A word completing on that edge is delivered normally.
- Overrun rule: if rx_valid fires while the core has not consumed the previous word, set overrun. The core consumes a word via the same cycle as rx_valid, i.e. no backpressure exists. The overrun check is therefore defined as a second word completing within 2*WIDTH clk of the previous rx_valid. This case is only reachable if sclk violates the 8x ratio.
- tx buffer:
  - tx_load at any time updates the buffer; it takes effect at the next word start.
  - If tx_load is never asserted, the last loaded value is resent.
- clr_flags has priority over a same-cycle set.
- Timing constraints for the master: sclk high and low times ≥ SYNC_STAGES+2 clk; first sclk rising ≥ SYNC_STAGES+2 clk after sce falls.
- dc is don't-care except at the final rising edge of each word.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, SHIFT),
  - the WIDTH default,
  - the counter width constant $clog2(WIDTH+1),
  - the sync-depth default shared with spi_master.
- One sub-module, spi_sync_edge: a parameterised N-stage synchronizer with rise/fall outputs. It is instantiated for sce and sclk; plain sync only for mosi and dc.

Test Plan:
- Master sends 0xA3 with dc=0, div_factor=8 → exactly one rx_valid; rx_data=0xA3, rx_dc=0; frame_err=0.
- tx_load with 0x5C before the transfer, master sends 0x3A → master data_out=0x5C, rx_data=0x3A.
- Two back-to-back words 0x12 (dc=0) then 0x34 (dc=1) in one sce frame → two rx_valid pulses in order, rx_dc 0 then 1, busy high throughout.
- sce raised after 5 sclk rising edges → no rx_valid; frame_err=1 until clr_flags; the next full word 0xFF is received correctly.
- reset driven low mid-word (after bit 3), then released → all outputs at reset values immediately; the subsequent 0x81 transfer is received correctly.
- sce high, sclk toggled 16 times with mosi random → no rx_valid, miso=0, busy=0.
